// File: rtl/packer_pkg.sv
// Shared types and default sizing for the FIFO word packer.
package packer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_RATIO = 4;

endpackage : packer_pkg

// File: rtl/nibble_packer.sv
// Packs RATIO consecutive WIDTH-bit words from an ack-style FIFO into one wide
// word (lane 0 = first popped word in the LSBs), with flush for partial words.
module nibble_packer
  import packer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RATIO = DEF_RATIO
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         fifo_data,
  input  logic                     fifo_rdempty,
  output logic                     fifo_deq,
  input  logic                     flush,
  output logic [WIDTH*RATIO-1:0]   out_data,
  output logic [$clog2(RATIO):0]   out_count,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int                CW         = $clog2(RATIO);
  localparam logic [CW-1:0]     LAST_LANE  = CW'(RATIO - 1);
  localparam logic [CW:0]       FULL_COUNT = (CW + 1)'(RATIO);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [WIDTH*RATIO-1:0]   data_q, data_d;
  logic [CW:0]              count_q, count_d;
  logic                     valid_q, valid_d;
  logic                     deq_s;

  // Gated by rstn so no pop is acknowledged while the packer is held in reset.
  assign deq_s    = (state_q == COLLECT) && !fifo_rdempty && rstn;
  assign fifo_deq = deq_s;

  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_valid = valid_q;

  // Next-state: lane capture, completion/flush into OUTPUT, handshake back to COLLECT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    case (state_q)
      COLLECT: begin
        if (deq_s) begin
          for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == CW'(i)) begin
              data_d[i*WIDTH +: WIDTH] = fifo_data;
            end else begin
              data_d[i*WIDTH +: WIDTH] = data_q[i*WIDTH +: WIDTH];
            end
          end
          if (cnt_q == LAST_LANE) begin
            state_d = OUTPUT;
            valid_d = 1'b1;
            count_d = FULL_COUNT;
            cnt_d   = {CW{1'b0}};
          end else if (flush) begin
            // Capture first, then emit the partial word including this lane.
            state_d = OUTPUT;
            valid_d = 1'b1;
            count_d = {1'b0, cnt_q} + (CW + 1)'(1);
            cnt_d   = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (flush && (cnt_q != {CW{1'b0}})) begin
          state_d = OUTPUT;
          valid_d = 1'b1;
          count_d = {1'b0, cnt_q};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = COLLECT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = COLLECT;
          valid_d = 1'b0;
          data_d  = {(WIDTH*RATIO){1'b0}};
          count_d = {(CW + 1){1'b0}};
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = {CW{1'b0}};
        data_d  = {(WIDTH*RATIO){1'b0}};
        count_d = {(CW + 1){1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial or pending word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= COLLECT;
      cnt_q   <= {CW{1'b0}};
      data_q  <= {(WIDTH*RATIO){1'b0}};
      count_q <= {(CW + 1){1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

endmodule : nibble_packer

// File: tb/tb_nibble_packer.sv
// Directed bench: a 4-deep, 4-bit ack-style FIFO feeds nibble_packer.
module tb_nibble_packer;

  logic        clk;
  logic        rstn;
  logic [3:0]  fifo_data;
  logic        fifo_rdempty;
  logic        fifo_deq;
  logic        flush;
  logic [15:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  logic        wr_en;
  logic [3:0]  wr_data;
  logic [3:0]  mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  fcnt;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  nibble_packer #(.WIDTH(4), .RATIO(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .fifo_data    (fifo_data),
    .fifo_rdempty (fifo_rdempty),
    .fifo_deq     (fifo_deq),
    .flush        (flush),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO: head word is visible whenever it is not empty.
  assign fifo_data    = mem[rp];
  assign fifo_rdempty = (fcnt == 3'd0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp   <= 2'd0;
      rp   <= 2'd0;
      fcnt <= 3'd0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp + 2'd1;
      end
      if (fifo_deq) rp <= rp + 2'd1;
      fcnt <= fcnt + {2'd0, wr_en} - {2'd0, fifo_deq};
    end
  end

  always @(negedge clk) begin
    if (rstn && fifo_deq && fifo_rdempty) viol <= viol + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 4'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {16'd0, out_data},  32'd0);
    chk("rst_count", {29'd0, out_count}, 32'd0);
    chk("rst_deq",   {31'd0, fifo_deq},  32'd0);
    rstn = 1'b1;
    step();

    // Back-to-back 8,6,7,3
    push(4'h8);
    push(4'h6);
    push(4'h7);
    push(4'h3);
    chk("b2b_deq4", {31'd0, fifo_deq},  32'd1);
    chk("b2b_pre",  {31'd0, out_valid}, 32'd0);
    step();
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_data",  {16'd0, out_data},  32'h3768);
    chk("b2b_count", {29'd0, out_count}, 32'd4);
    step();
    chk("b2b_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_hs_data",  {16'd0, out_data},  32'd0);
    chk("b2b_hs_count", {29'd0, out_count}, 32'd0);

    // Backpressure with words waiting in the FIFO
    out_ready = 1'b0;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    push(4'h5);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_data0", {16'd0, out_data},  32'h4321);
    push(4'h6);
    for (int i = 0; i < 3; i++) begin
      chk("bp_data",  {16'd0, out_data},  32'h4321);
      chk("bp_count", {29'd0, out_count}, 32'd4);
      chk("bp_deq",   {31'd0, fifo_deq},  32'd0);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_fcnt",  {29'd0, fcnt},      32'd2);
    chk("bp_resume",   {31'd0, fifo_deq},  32'd1);
    step();
    step();
    chk("bp_drained", {31'd0, fifo_rdempty}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("bp_fl_data",  {16'd0, out_data},  32'h0065);
    chk("bp_fl_count", {29'd0, out_count}, 32'd2);
    step();

    // Flush with FIFO empty, then flush with nothing collected
    push(4'h5);
    push(4'hA);
    step();
    flush = 1'b1;
    step();
    chk("fl_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_data",  {16'd0, out_data},  32'h00A5);
    chk("fl_count", {29'd0, out_count}, 32'd2);
    step();
    chk("fl_hs_valid", {31'd0, out_valid}, 32'd0);
    step();
    step();
    chk("fl_empty_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;

    // Flush coincident with the third pop
    push(4'h1);
    push(4'h2);
    push(4'h3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flp_valid", {31'd0, out_valid}, 32'd1);
    chk("flp_data",  {16'd0, out_data},  32'h0321);
    chk("flp_count", {29'd0, out_count}, 32'd3);
    step();

    // Reset mid-collection discards the partial word
    push(4'h9);
    push(4'h9);
    step();
    rstn = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_deq",   {31'd0, fifo_deq},  32'd0);
    step();
    chk("mr_valid2", {31'd0, out_valid}, 32'd0);
    rstn = 1'b1;
    step();
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    step();
    chk("mr_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mr_data",      {16'd0, out_data},  32'h4321);
    step();

    // One-cycle gaps between enqueues
    push(4'h9);
    step();
    chk("gap_deq0", {31'd0, fifo_deq}, 32'd0);
    push(4'hB);
    step();
    push(4'hC);
    step();
    push(4'hD);
    step();
    chk("gap_valid", {31'd0, out_valid}, 32'd1);
    chk("gap_data",  {16'd0, out_data},  32'hDCB9);
    chk("gap_count", {29'd0, out_count}, 32'd4);
    step();
    chk("deq_vs_empty", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nibble_packer
